// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the cache-to-memory arbiter.
// FSM state encoding lives here so every unit agrees on it.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } arb_state_t;

   localparam int DEF_ADDR_W = 28;
   localparam int DEF_LINE_W = 128;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after i_last.
// Searches i_last+1 .. i_last+N, wrapping at N.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);

   int w_c;

   // scan forward from the channel after the last grant
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      w_c     = 0;
      for (int i = 1; i <= N; i++) begin
         w_c = int'(i_last) + i;
         if (w_c >= N) w_c = w_c - N;
         if (!o_valid && i_req[IW'(w_c)]) begin
            o_idx   = IW'(w_c);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slow line memory among cache channels.
// Define MEM_ARBITER_PERF_EN to build the per-channel wait counters.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LINE_W = DEF_LINE_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        ch_read,
   input  logic [NUM_CH-1:0]        ch_write,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
   input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
   output logic [LINE_W-1:0]        ch_rdata,
   output logic [NUM_CH-1:0]        ch_ready,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [LINE_W-1:0]        mem_wdata,
   input  logic [LINE_W-1:0]        mem_rdata,
   input  logic                     mem_ready,
   output logic [NUM_CH*32-1:0]     perf_wait
);

   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   arb_state_t          r_state;
   logic [IW-1:0]       r_grant;
   logic                r_wr;
   logic [ADDR_W-1:0]   r_addr;
   logic [LINE_W-1:0]   r_wdata;
   logic                r_mem_read;
   logic                r_mem_write;
   logic [LINE_W-1:0]   r_rdata;
   logic [NUM_CH-1:0]   r_ready;

   logic [NUM_CH-1:0]   w_req;
   logic [IW-1:0]       w_pick;
   logic                w_valid;

   assign w_req = ch_read | ch_write;

   rr_pick #(
      .N  (NUM_CH),
      .IW (IW)
   ) u_pick (
      .i_req   (w_req),
      .i_last  (r_grant),
      .o_idx   (w_pick),
      .o_valid (w_valid)
   );

   // grant, hold the latched request stable, then pulse ready once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_grant     <= IW'(NUM_CH - 1);
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_rdata     <= '0;
         r_ready     <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_valid) begin
                  r_grant     <= w_pick;
                  r_wr        <= ch_write[w_pick];
                  r_addr      <= ch_addr[int'(w_pick)*ADDR_W +: ADDR_W];
                  r_wdata     <= ch_wdata[int'(w_pick)*LINE_W +: LINE_W];
                  r_mem_read  <= ~ch_write[w_pick];
                  r_mem_write <= ch_write[w_pick];
                  r_state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (mem_ready) begin
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
                  if (!r_wr) r_rdata <= mem_rdata;
                  r_ready     <= NUM_CH'(1) << r_grant;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               r_ready <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign ch_rdata  = r_rdata;
   assign ch_ready  = r_ready;

`ifdef MEM_ARBITER_PERF_EN
   logic [31:0] r_perf [NUM_CH];

   // count cycles a channel requests without being the active grantee
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_CH; k++) r_perf[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (w_req[k]
                && !(r_state != S_IDLE && r_grant == IW'(k))
                && r_perf[k] != 32'hFFFF_FFFF)
               r_perf[k] <= r_perf[k] + 32'd1;
         end
      end
   end

   // flatten the counters onto the output bus
   always_comb begin
      perf_wait = '0;
      for (int k = 0; k < NUM_CH; k++) perf_wait[k*32 +: 32] = r_perf[k];
   end
`else
   assign perf_wait = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus corner sequences.
// Perf expectations follow MEM_ARBITER_PERF_EN.
module tb_mem_arbiter;

   localparam int NC = 2;
   localparam int AW = 28;
   localparam int LW = 128;

   localparam logic [LW-1:0] LINE_A = 128'hA5A5_0123_4567_89AB_CDEF_FEDC_BA98_7654;
   localparam logic [LW-1:0] W0     = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [LW-1:0] W1     = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

`ifdef MEM_ARBITER_PERF_EN
   localparam logic [31:0] EXP_P1 = 32'd8;
   localparam logic [31:0] EXP_P0 = 32'd1;
`else
   localparam logic [31:0] EXP_P1 = 32'd0;
   localparam logic [31:0] EXP_P0 = 32'd0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NC-1:0]     ch_read = '0;
   logic [NC-1:0]     ch_write = '0;
   logic [NC*AW-1:0]  ch_addr = '0;
   logic [NC*LW-1:0]  ch_wdata = {W1, W0};
   logic [LW-1:0]     ch_rdata;
   logic [NC-1:0]     ch_ready;
   logic              mem_read;
   logic              mem_write;
   logic [AW-1:0]     mem_addr;
   logic [LW-1:0]     mem_wdata;
   logic [LW-1:0]     mem_rdata = LINE_A;
   logic              mem_ready = 1'b0;
   logic [NC*32-1:0]  perf_wait;

   always #5 clk = ~clk;

   mem_arbiter #(
      .NUM_CH (NC),
      .ADDR_W (AW),
      .LINE_W (LW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ch_read   (ch_read),
      .ch_write  (ch_write),
      .ch_addr   (ch_addr),
      .ch_wdata  (ch_wdata),
      .ch_rdata  (ch_rdata),
      .ch_ready  (ch_ready),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .perf_wait (perf_wait)
   );

   typedef struct {
      bit          rst;
      logic [1:0]  rd;
      logic [1:0]  wr;
      logic [27:0] a0;
      logic [27:0] a1;
      logic        mrdy;
      logic [1:0]  e_rw;
      logic [27:0] e_addr;
      logic [1:0]  e_rdy;
      logic [127:0] e_rdata;
   } vec_t;

   vec_t tv[$];
   int   errs = 0;
   int   checks = 0;

   task automatic chk(input string nm, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic add(input bit r, input logic [1:0] rd, input logic [1:0] wr,
                      input logic [27:0] a0, input logic [27:0] a1,
                      input logic mr, input logic [1:0] erw,
                      input logic [27:0] ea, input logic [1:0] er,
                      input logic [127:0] ed);
      vec_t v;
      v.rst = r; v.rd = rd; v.wr = wr; v.a0 = a0; v.a1 = a1;
      v.mrdy = mr; v.e_rw = erw; v.e_addr = ea; v.e_rdy = er;
      v.e_rdata = ed;
      tv.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      ch_read   = '0;
      ch_write  = '0;
      mem_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // single ch0 read, memory ready in the 4th busy cycle
      add(1, 2'b01, 2'b00, 28'h10, 28'h0, 0, 2'b10, 28'h10, 2'b00, '0);
      add(0, 2'b00, 2'b00, 28'h10, 28'h0, 0, 2'b10, 28'h10, 2'b00, '0);
      add(0, 2'b00, 2'b00, 28'h10, 28'h0, 0, 2'b10, 28'h10, 2'b00, '0);
      add(0, 2'b00, 2'b00, 28'h10, 28'h0, 0, 2'b10, 28'h10, 2'b00, '0);
      add(0, 2'b00, 2'b00, 28'h10, 28'h0, 1, 2'b00, 28'h10, 2'b01, LINE_A);
      add(0, 2'b00, 2'b00, 28'h10, 28'h0, 0, 2'b00, 28'h10, 2'b00, LINE_A);
      // simultaneous ch0+ch1 twice: ch0 then ch1 each round
      add(1, 2'b11, 2'b00, 28'h20, 28'h30, 0, 2'b10, 28'h20, 2'b00, '0);
      add(0, 2'b11, 2'b00, 28'h20, 28'h30, 1, 2'b00, 28'h20, 2'b01, LINE_A);
      add(0, 2'b10, 2'b00, 28'h20, 28'h30, 0, 2'b00, 28'h20, 2'b00, LINE_A);
      add(0, 2'b10, 2'b00, 28'h20, 28'h30, 0, 2'b10, 28'h30, 2'b00, LINE_A);
      add(0, 2'b00, 2'b00, 28'h20, 28'h30, 1, 2'b00, 28'h30, 2'b10, LINE_A);
      add(0, 2'b00, 2'b00, 28'h20, 28'h30, 0, 2'b00, 28'h30, 2'b00, LINE_A);
      add(0, 2'b11, 2'b00, 28'h20, 28'h30, 0, 2'b10, 28'h20, 2'b00, LINE_A);
      add(0, 2'b11, 2'b00, 28'h20, 28'h30, 1, 2'b00, 28'h20, 2'b01, LINE_A);
      add(0, 2'b10, 2'b00, 28'h20, 28'h30, 0, 2'b00, 28'h20, 2'b00, LINE_A);
      add(0, 2'b10, 2'b00, 28'h20, 28'h30, 0, 2'b10, 28'h30, 2'b00, LINE_A);
      add(0, 2'b00, 2'b00, 28'h20, 28'h30, 1, 2'b00, 28'h30, 2'b10, LINE_A);
      add(0, 2'b00, 2'b00, 28'h20, 28'h30, 0, 2'b00, 28'h30, 2'b00, LINE_A);
      // read+write together on ch0 is a write
      add(1, 2'b01, 2'b01, 28'h40, 28'h0, 0, 2'b01, 28'h40, 2'b00, '0);
      add(0, 2'b00, 2'b00, 28'h40, 28'h0, 1, 2'b00, 28'h40, 2'b01, '0);
      add(0, 2'b00, 2'b00, 28'h40, 28'h0, 0, 2'b00, 28'h40, 2'b00, '0);

      #1;
      chk("rst mem_read", mem_read, 1'b0);
      chk("rst ch_ready", ch_ready, 2'b00);
      chk("rst perf", perf_wait, '0);

      for (int i = 0; i < tv.size(); i++) begin
         if (tv[i].rst) do_reset();
         ch_read   = tv[i].rd;
         ch_write  = tv[i].wr;
         ch_addr   = {tv[i].a1, tv[i].a0};
         mem_ready = tv[i].mrdy;
         tick();
         chk($sformatf("v%0d rw", i), {mem_read, mem_write}, tv[i].e_rw);
         chk($sformatf("v%0d addr", i), mem_addr, tv[i].e_addr);
         chk($sformatf("v%0d ready", i), ch_ready, tv[i].e_rdy);
         chk($sformatf("v%0d rdata", i), ch_rdata, tv[i].e_rdata);
      end

      // ch1 write stays stable while its inputs change mid-busy
      do_reset();
      ch_write = 2'b10;
      ch_addr  = {28'h50, 28'h0};
      tick();
      chk("wr mem_write", mem_write, 1'b1);
      chk("wr mem_read", mem_read, 1'b0);
      chk("wr addr", mem_addr, 28'h50);
      chk("wr wdata", mem_wdata, W1);
      ch_write = '0;
      ch_addr  = {28'h77, 28'h0};
      ch_wdata = {128'h0, W0};
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("wr hold addr%0d", i), mem_addr, 28'h50);
         chk($sformatf("wr hold data%0d", i), mem_wdata, W1);
         chk($sformatf("wr hold en%0d", i), mem_write, 1'b1);
      end
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("wr ready", ch_ready, 2'b10);
      chk("wr drop", mem_write, 1'b0);
      tick();
      chk("wr ready off", ch_ready, 2'b00);
      ch_wdata = {W1, W0};

      // asynchronous reset in the middle of a transaction
      ch_read = 2'b10;
      ch_addr = {28'h60, 28'h0};
      tick();
      ch_read   = '0;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      chk("pre rdata", ch_rdata, LINE_A);
      ch_read = 2'b10;
      ch_addr = {28'h61, 28'h0};
      tick();
      chk("pre busy rd", mem_read, 1'b1);
      chk("pre busy addr", mem_addr, 28'h61);
      ch_read = '0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst rw", {mem_read, mem_write}, 2'b00);
      chk("arst addr", mem_addr, 28'h0);
      chk("arst wdata", mem_wdata, '0);
      chk("arst rdata", ch_rdata, '0);
      chk("arst ready", ch_ready, 2'b00);
      chk("arst perf", perf_wait, '0);
      @(negedge clk);
      rst_n   = 1'b1;
      ch_read = 2'b11;
      ch_addr = {28'h71, 28'h70};
      tick();
      chk("post grant addr", mem_addr, 28'h70);
      chk("post grant rd", mem_read, 1'b1);
      ch_read   = '0;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("post ready", ch_ready, 2'b01);
      tick();

      // ch1 waits behind a 5-busy + 1-resp ch0 transaction
      do_reset();
      ch_read = 2'b11;
      ch_addr = {28'h30, 28'h20};
      tick();
      repeat (4) tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      ch_read   = 2'b10;
      tick();
      tick();
      chk("perf grant ch1", mem_addr, 28'h30);
      chk("perf ch1", perf_wait[63:32], EXP_P1);
      chk("perf ch0", perf_wait[31:0], EXP_P0);
      ch_read   = '0;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      chk("perf ch1 hold", perf_wait[63:32], EXP_P1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of cache requester channels (range 1..8).
- REQ-002 SHALL have parameter ADDR_W, default 28, meaning the line address width (byte address bits [31:4]).
- REQ-003 SHALL have parameter LINE_W, default 128, meaning the line data width.
- REQ-004 SHALL have port clk, input, 1, the single clock; one clock; reset is asynchronous and active-low.
- REQ-005 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
- REQ-006 SHALL have port ch_read, input, NUM_CH, the per-channel line read request.
- REQ-007 SHALL have port ch_write, input, NUM_CH, the per-channel line write request.
- REQ-008 SHALL have port ch_addr, input, NUM_CH*ADDR_W, the flattened per-channel line addresses; channel k occupies [k*ADDR_W +: ADDR_W].
- REQ-009 SHALL have port ch_wdata, input, NUM_CH*LINE_W, the flattened per-channel write lines.
- REQ-010 SHALL have port ch_rdata, output, LINE_W, the read line broadcast to all channels.
- REQ-011 SHALL have port ch_ready, output, NUM_CH, the per-channel completion pulse.
- REQ-012 SHALL have ports mem_read (output, 1), mem_write (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, LINE_W), forming the shared slow-memory request.
- REQ-013 SHALL have ports mem_rdata (input, LINE_W) and mem_ready (input, 1), forming the slow-memory response.
- REQ-014 SHALL have port perf_wait, output, NUM_CH*32, the per-channel wait-cycle counters.

Function
- REQ-015 SHALL implement a three-state FSM: IDLE, BUSY, RESP.
- REQ-016 SHALL, in IDLE when any channel has ch_read|ch_write set, round-robin grant starting from last_grant+1 (wrapping at NUM_CH), latch that channel's type, addr and wdata, and enter BUSY at the next edge.
- REQ-017 SHALL, in BUSY, drive mem_read/mem_write/mem_addr/mem_wdata from the latched values only, so memory sees a stable request even if the requester changes its inputs.
- REQ-018 SHALL treat ch_read and ch_write both high on one channel as a write (mem_write=1, mem_read=0).
- REQ-019 SHALL, in BUSY on mem_ready=1, capture mem_rdata into ch_rdata, deassert mem_read/mem_write, and enter RESP at the next edge.
- REQ-020 SHALL, in RESP, hold ch_ready[grant]=1 for exactly one cycle with all other ch_ready bits 0, then return to IDLE.
- REQ-021 SHALL give a minimum latency from request (in IDLE) to ch_ready of 2 cycles plus the memory latency; ch_rdata SHALL hold its value until the next captured read.
- REQ-022 SHALL ignore request changes on non-granted channels during BUSY/RESP; new requests are considered only in IDLE.
- REQ-023 SHALL, with NUM_CH=1, always grant channel 0 with identical timing.

Reset
- REQ-024 SHALL, on rst_n=0 (asynchronous, including mid-transaction), go to IDLE with mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, ch_ready=0, ch_rdata=0, perf_wait=0, and last_grant=NUM_CH-1 so that channel 0 wins first.

Configuration
- REQ-025 SHALL, with MEM_ARBITER_PERF_EN defined, increment perf_wait[k] on every cycle in which channel k requests and is not in BUSY/RESP as grantee, saturating at 32'hFFFFFFFF.
- REQ-026 SHALL, without MEM_ARBITER_PERF_EN, tie perf_wait to 0 and contain no counter logic.

Structure
- REQ-027 SHALL place the FSM state enum and the default ADDR_W/LINE_W constants in the shared package mem_arbiter_pkg.
- REQ-028 SHALL implement the next-grant calculation in a combinational sub-module rr_pick (inputs: request vector and last_grant; output: grant index and valid).

Verification
- REQ-029 SHALL verify that ch0 read addr 28'h0000010 with memory ready after 4 cycles gives mem_read=1 for 4 cycles and ch_ready[0] pulses once with ch_rdata equal to the memory line.
- REQ-030 SHALL verify that ch0 and ch1 requesting simultaneously out of reset are served ch0 then ch1, and that a repeat simultaneous request is served ch0 then ch1 again.
- REQ-031 SHALL verify that a ch1 write with wdata 128'hDEADBEEF... whose ch_addr changes mid-BUSY still presents the original mem_addr/mem_wdata until mem_ready.
- REQ-032 SHALL verify that ch0 read=1 and write=1 together produce mem_write=1 and mem_read=0.
- REQ-033 SHALL verify that rst_n pulsed low during BUSY drops all outputs to 0 immediately, and that the first post-reset grant goes to ch0.
- REQ-034 SHALL verify, with MEM_ARBITER_PERF_EN defined, that ch1 waiting during a 6-cycle ch0 transaction makes perf_wait[1] increment by the number of its waiting cycles (8); without the macro, perf_wait stays 0.
